// File: rtl/frame_bram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// frame_bram_rd_arbiter
//
// Shares the single frame BRAM read port between two burst-read requesters
// (port 0: VGA line fetcher, port 1: overlay/debug reader) in clk_ddr.
// A request is granted as a whole burst. The burst is then issued as
// sequential addresses, one per cycle. Each issued beat is tagged with its
// owner so the returned word, RD_LAT cycles later, is steered to the right
// response port. Responses may still be draining while the next burst is
// accepted and issued.
//
// Ports
//   clk_ddr, reset           clock, synchronous active-high reset
//   reqN_valid/ready         burst request handshake (ready is a 1-cycle pulse)
//   reqN_addr, reqN_len      burst start address and word count (0 means 1)
//   rspN_valid, rspN_last    per-port read data strobe and end-of-burst flag
//   rsp_data                 shared read data (frame_bram_data_in passthrough)
//   frame_bram_en_out/addr   BRAM read enable and address
//   frame_bram_data_in       BRAM read data, valid RD_LAT cycles after en
//   busy                     burst issuing or any read still in flight
//   grant_id                 owner of the current or most recent burst
// -----------------------------------------------------------------------------
module frame_bram_rd_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 20,
  parameter int LEN_W        = 7,
  parameter int RD_LAT       = 2,
  parameter int PRIO0        = 0,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk_ddr,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              rsp0_valid,
  output logic              rsp0_last,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              rsp1_valid,
  output logic              rsp1_last,
  output logic [DATA_W-1:0] rsp_data,
  output logic              frame_bram_en_out,
  output logic [ADDR_W-1:0] frame_bram_addr_out,
  input  logic [DATA_W-1:0] frame_bram_data_in,
  output logic              busy,
  output logic              grant_id
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              r_state;
  logic                r_last;       // round-robin pointer: last port granted
  logic [STARVE_W-1:0] r_starve;     // cycles port 1 has waited (fixed priority)
  logic [LEN_W-1:0]    r_rem;        // beats still to issue after the current one
  logic                r_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_grant;
  // One entry per pipeline stage of the BRAM read: {valid, owner, last}.
  logic [RD_LAT-1:0]   r_tag_v;
  logic [RD_LAT-1:0]   r_tag_id;
  logic [RD_LAT-1:0]   r_tag_last;

  logic                w_starved;
  logic                w_pick1;
  logic                w_idle;
  logic                w_acc0;
  logic                w_acc1;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [LEN_W-1:0]    w_len_sel;
  logic [LEN_W-1:0]    w_rem_init;
  logic                w_beat_last;

  // Winner selection looks only at requests and registered state, so ready
  // never depends on anything this block drives combinationally.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_starved  = 1'b0;
    w_pick1    = 1'b0;
    w_rem_init = '0;
    if (PRIO0 != 0) begin
      w_starved = (r_starve >= STARVE_W'(STARVE_LIMIT));
      w_pick1   = req1_valid && (!req0_valid || w_starved);
    end else begin
      // On a tie the port that did not win last time goes next.
      w_pick1   = req1_valid && (!req0_valid || !r_last);
    end
    w_len_sel  = w_pick1 ? req1_len  : req0_len;
    w_addr_sel = w_pick1 ? req1_addr : req0_addr;
    // A zero-length request still reads one word.
    if (w_len_sel != '0) w_rem_init = w_len_sel - LEN_W'(1);
  end

  // Reset is folded into ready so nothing is handshaken while the state is
  // being cleared.
  assign w_idle      = (r_state == S_IDLE) && !reset;
  assign w_acc0      = w_idle && req0_valid && !w_pick1;
  assign w_acc1      = w_idle && w_pick1;
  assign w_beat_last = r_en && (r_rem == '0);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register below sees the pre-edge value of every other register.
  always_ff @(posedge clk_ddr) begin
    // NOTE: the tag pipeline is small flops, not a RAM, so it is reset; that
    // is what drops in-flight words when reset hits mid-burst.
    if (reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_starve   <= '0;
      r_rem      <= '0;
      r_en       <= 1'b0;
      r_addr     <= '0;
      r_grant    <= 1'b0;
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_tag_last <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_state <= S_ISSUE;
            r_en    <= 1'b1;
            r_addr  <= w_addr_sel;
            r_rem   <= w_rem_init;
            r_grant <= w_pick1;
            r_last  <= w_pick1;
          end
        end
        S_ISSUE: begin
          // Leaving here after the final beat gives the mandatory en=0 gap.
          if (r_rem == '0) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
          end else begin
            r_addr  <= r_addr + 1'b1;   // wraps modulo 2^ADDR_W
            r_rem   <= r_rem - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_id[i]   <= r_tag_id[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_tag_v[0]    <= r_en;
      r_tag_id[0]   <= r_grant;
      r_tag_last[0] <= w_beat_last;

      // Starvation guard: counts port 1 waiting time, saturating.
      if (PRIO0 == 0 || !req1_valid || w_acc1) begin
        r_starve <= '0;
      end else if (r_starve < STARVE_W'(STARVE_LIMIT)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  assign req0_ready          = w_acc0;
  assign req1_ready          = w_acc1;
  assign frame_bram_en_out   = r_en;
  assign frame_bram_addr_out = r_addr;
  assign rsp_data            = frame_bram_data_in;
  assign rsp0_valid          = r_tag_v[RD_LAT-1] && !r_tag_id[RD_LAT-1];
  assign rsp1_valid          = r_tag_v[RD_LAT-1] &&  r_tag_id[RD_LAT-1];
  assign rsp0_last           = rsp0_valid && r_tag_last[RD_LAT-1];
  assign rsp1_last           = rsp1_valid && r_tag_last[RD_LAT-1];
  assign busy                = (r_state == S_ISSUE) || (|r_tag_v);
  assign grant_id            = r_grant;

endmodule

// File: doc/frame_bram_rd_arbiter.md
Name: frame_bram_rd_arbiter

Overview:
- Shares the single frame BRAM read port (frame_bram_en_out / frame_bram_addr_out / frame_bram_data_in) between two burst-read requesters: port 0 is the VGA line fetcher, port 1 is a secondary reader such as overlay or debug readback.
- Grants whole bursts, issues sequential addresses and tags in-flight reads so each returned word is routed to its owner.
- Sits in the clk_ddr domain beside the DDR2-to-BRAM path.

Parameters:
- ADDR_W, 14, frame BRAM address width.
- DATA_W, 20, frame BRAM data width.
- LEN_W, 7, burst length field width. Max burst is 2^LEN_W-1.
- RD_LAT, 2, BRAM read latency in cycles from en/addr to valid data_in. Legal range is 1..4.
- PRIO0, 0. 0 selects round-robin. 1 selects fixed priority to port 0 with starvation guard.
- STARVE_LIMIT, 16, cycles port 1 may wait while valid before it is forced to win. Used only when PRIO0=1.

Ports:
- clk_ddr  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- req0_valid  in  1  port 0 burst request.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_addr  in  ADDR_W  port 0 start address.
- req0_len  in  LEN_W  port 0 word count.
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_last  out  1  final word of port 0 burst.
- req1_valid / req1_ready / req1_addr / req1_len  same as port 0, for port 1.
- rsp1_valid / rsp1_last  same as port 0, for port 1.
- rsp_data  out  DATA_W  shared read data, equal to frame_bram_data_in.
- frame_bram_en_out  out  1  BRAM read enable.
- frame_bram_addr_out  out  ADDR_W  BRAM read address.
- frame_bram_data_in  in  DATA_W  BRAM read data.
- busy  out  1  high in ISSUE or while any read is in flight.
- grant_id  out  1  owner of the current or last burst.

Behaviour:
- Reset values: all outputs 0. State is IDLE. Round-robin pointer last=1, so port 0 wins the first tie. Starvation counter 0. Tag pipeline cleared.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - Arbitration is evaluated on registered state only, no combinational loops.
  - Winner selection:
    - PRIO0=0: if both valid, the port not equal to last wins. Otherwise the single valid port wins.
    - PRIO0=1: port 0 wins unless port 1 is valid and the starvation counter is >= STARVE_LIMIT.
  - The winner's ready pulses high for exactly one cycle (the accept cycle T).
  - On accept: latch addr and len, set grant_id and last to the winner, move to ISSUE.
  - len=0 is treated as 1.
- ISSUE:
  - Beat k (k=0..len-1) occurs at cycle T+1+k with en=1 and addr=start+k, computed modulo 2^ADDR_W (0x3FFF wraps to 0x0000).
  - After the final beat, return to IDLE.
  - One idle cycle (en=0) always separates bursts.
- Response path:
  - An RD_LAT-deep shift register carries {valid, id, last} per issued beat.
  - rspN_valid is high at cycle T+1+k+RD_LAT when the tag id=N. rspN_last is high with the final beat.
  - Responses overlap the next burst's accept and issue. Tags keep them correctly routed.
  - Responses have no backpressure. Requesters must sink every word.
- Starvation counter (PRIO0=1 only):
  - Increments each cycle req1_valid is high and port 1 is not accepted.
  - Saturates at STARVE_LIMIT.
  - Clears on port 1 accept or when req1_valid is low.
- Request hold rule: requesters hold valid, addr and len stable until ready. Deasserting valid before ready withdraws the request with no side effect.
- busy = (state==ISSUE) OR (any tag valid).
- Reset mid-burst: the next cycle has en=0, the tag pipeline is cleared, and no further rsp valid is produced. In-flight words are dropped.

Test Plan:
1. RD_LAT=2; BRAM model returns data = addr. req0 addr 0x0100 len 4 accepted at T -> en high T+1..T+4 with addr 0x100..0x103. rsp0_valid at T+3..T+6 with data 0x100..0x103. rsp0_last at T+6. rsp1_valid never high.
2. PRIO0=0; both ports valid continuously with len 2 after reset -> grants go 0,1,0,1. Each ready pulse lasts 1 cycle, with a 1-cycle en gap between bursts.
3. req1 addr 0x3FFE len 4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001. rsp1_last on the 4th word.
4. req0 len 2 then req1 len 3 back-to-back with RD_LAT=3 -> port 0 responses complete while port 1 issues. rsp0 gets exactly 2 words and rsp1 gets exactly 3, with no misrouting.
5. PRIO0=1, STARVE_LIMIT=8; req0 valid continuously with len 1, req1 valid from cycle 0 -> req1_ready is asserted once the counter reaches 8, then the counter clears.
6. reset asserted at beat 2 of a len 8 burst -> next cycle en=0, all rsp valid=0, ready=0, busy=0. After release, req0 len 1 completes normally.
